// File: rtl/ccg_bist_pkg.sv
// Shared types and defaults for the CCG BIST engine (FSM states, default polynomials).
package ccg_bist_pkg;

  typedef enum logic [2:0] {IDLE, SEED, RUN, DRAIN, DONE} state_t;

  localparam logic [26:0] DEF_TPG_POLY  = 27'h0000027;
  localparam logic [26:0] DEF_MISR_POLY = 27'h0000027;
  localparam int          MAX_CUT_LAT   = 7;

endpackage

// File: rtl/ccg_lfsr_misr.sv
// Galois shift register with clear/load/step; MISR_MODE folds a parallel data word into each step.
// q_next exposes the value the register takes at the next edge.
module ccg_lfsr_misr #(
  parameter int               WIDTH     = 27,
  parameter logic [WIDTH-1:0] POLY      = '0,
  parameter bit               MISR_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    if (clr) begin
      q_next = '0;
    end else if (load) begin
      q_next = load_val;
    end else if (step) begin
      q_next = {q[WIDTH-2:0], 1'b0} ^ (q[WIDTH-1] ? POLY : '0);
      if (MISR_MODE) q_next = q_next ^ din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q <= '0;
    else        q <= q_next;
  end

endmodule

// File: rtl/ccg_bist_engine.sv
// LFSR-driven BIST wrapper for a combinational/pipelined CUT with MISR response compaction.
// Optional per-pattern failure logging is enabled by defining CCG_BIST_FAIL_LOG_EN.
module ccg_bist_engine
  import ccg_bist_pkg::*;
#(
  parameter int              N_IN      = 27,
  parameter int              N_OUT     = 27,
  parameter logic [N_IN-1:0] TPG_POLY  = N_IN'(DEF_TPG_POLY),
  parameter logic [N_OUT-1:0] MISR_POLY = N_OUT'(DEF_MISR_POLY),
  parameter int              CUT_LAT   = 0,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [N_IN-1:0]  seed,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [N_OUT-1:0] exp_sig,
  output logic [N_IN-1:0]  cut_in,
  input  logic [N_OUT-1:0] cut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_OUT-1:0] signature
`ifdef CCG_BIST_FAIL_LOG_EN
  ,
  input  logic [N_OUT-1:0] exp_resp,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             fail_seen
`endif
);

  localparam int DW = $clog2(MAX_CUT_LAT + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'((CUT_LAT > 0) ? CUT_LAT - 1 : 0);

  state_t           state;
  logic [N_IN-1:0]  seed_r;
  logic [CNT_W-1:0] np_r;
  logic [N_OUT-1:0] exp_r;
  logic [CNT_W-1:0] cnt;
  logic [DW-1:0]    drain_cnt;
  logic             start_acc, issue, last, cap;
  logic [N_OUT-1:0] sig_next;
  logic [N_IN-1:0]  tpg_next_unused;

  assign start_acc = start & ~abort & ((state == IDLE) | (state == DONE));
  assign issue     = (state == RUN);
  assign last      = (cnt == np_r - 1'b1);

  // A response is compacted CUT_LAT cycles after its pattern was on cut_in.
  generate
    if (CUT_LAT == 0) begin : g_nopipe
      assign cap = issue;
    end else begin : g_pipe
      logic [CUT_LAT:1] vld_pipe;
      always_ff @(posedge clk) begin
        if (!rst_n || abort || start_acc) begin
          vld_pipe <= '0;
        end else begin
          vld_pipe[1] <= issue;
          for (int k = 2; k <= CUT_LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
        end
      end
      assign cap = vld_pipe[CUT_LAT];
    end
  endgenerate

  // The last pattern is held on cut_in through DRAIN/DONE.
  ccg_lfsr_misr #(.WIDTH(N_IN), .POLY(TPG_POLY), .MISR_MODE(1'b0)) u_tpg (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (1'b0),
    .load     ((state == SEED) & ~abort),
    .load_val (seed_r),
    .step     (issue & ~last & ~abort),
    .din      ('0),
    .q        (cut_in),
    .q_next   (tpg_next_unused)
  );

  ccg_lfsr_misr #(.WIDTH(N_OUT), .POLY(MISR_POLY), .MISR_MODE(1'b1)) u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (start_acc),
    .load     (1'b0),
    .load_val ('0),
    .step     (cap & ~abort),
    .din      (cut_out),
    .q        (signature),
    .q_next   (sig_next)
  );

  // pass uses sig_next so the final compaction, which lands on the DONE edge, is included.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      seed_r    <= '0;
      np_r      <= '0;
      exp_r     <= '0;
      cnt       <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            seed_r <= (seed == '0) ? N_IN'(1) : seed;
            np_r   <= num_patterns;
            exp_r  <= exp_sig;
            busy   <= 1'b1;
            done   <= 1'b0;
            pass   <= 1'b0;
            state  <= SEED;
          end
        end
        SEED: begin
          cnt <= '0;
          if (np_r == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (sig_next == exp_r);
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (last) begin
            if (CUT_LAT > 0) begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (sig_next == exp_r);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (sig_next == exp_r);
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CCG_BIST_FAIL_LOG_EN
  logic [CNT_W-1:0] rsp_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || start_acc) begin
      rsp_cnt        <= '0;
      first_fail_idx <= '0;
      fail_seen      <= 1'b0;
    end else if (cap && !abort) begin
      rsp_cnt <= rsp_cnt + 1'b1;
      if (!fail_seen && (cut_out != exp_resp)) begin
        fail_seen      <= 1'b1;
        first_fail_idx <= rsp_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ccg_bist_engine.sv
// Scoreboard bench: a 4-bit loopback CUT (CUT_LAT=0) and a 2-stage registered loopback (CUT_LAT=2).
module tb_ccg_bist_engine;

  logic        clk = 1'b0;
  logic        rst_n, start0, start2, abort;
  logic [3:0]  seed, exp_sig;
  logic [15:0] num_patterns;
  logic [3:0]  ci0, co0, sg0, ci2, co2, sg2, r1, r2;
  logic        b0, d0, p0, b2, d2, p2;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [3:0]  pat_q[$];

  always #5 clk = ~clk;

  assign co0 = ci0;
  always_ff @(posedge clk) begin
    r1 <= ci2;
    r2 <= r1;
  end
  assign co2 = r2;

`ifdef CCG_BIST_FAIL_LOG_EN
  logic [15:0] ffi0, ffi2;
  logic        fs0, fs2;
`endif

  ccg_bist_engine #(.N_IN(4), .N_OUT(4), .TPG_POLY(4'h3), .MISR_POLY(4'h3),
                    .CUT_LAT(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort), .seed(seed),
    .num_patterns(num_patterns), .exp_sig(exp_sig), .cut_in(ci0), .cut_out(co0),
    .busy(b0), .done(d0), .pass(p0), .signature(sg0)
`ifdef CCG_BIST_FAIL_LOG_EN
    , .exp_resp(ci0), .first_fail_idx(ffi0), .fail_seen(fs0)
`endif
  );

  ccg_bist_engine #(.N_IN(4), .N_OUT(4), .TPG_POLY(4'h3), .MISR_POLY(4'h3),
                    .CUT_LAT(2), .CNT_W(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort), .seed(seed),
    .num_patterns(num_patterns), .exp_sig(exp_sig), .cut_in(ci2), .cut_out(co2),
    .busy(b2), .done(d2), .pass(p2), .signature(sg2)
`ifdef CCG_BIST_FAIL_LOG_EN
    , .exp_resp(r2), .first_fail_idx(ffi2), .fail_seen(fs2)
`endif
  );

  function automatic logic [3:0] gstep(input logic [3:0] s, input logic [3:0] d);
    return {s[2:0], 1'b0} ^ (s[3] ? 4'h3 : 4'h0) ^ d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  task automatic peek(input int lat, output logic [3:0] ci, output logic [3:0] sg,
                      output logic b, output logic d, output logic p);
    ci = (lat == 0) ? ci0 : ci2;
    sg = (lat == 0) ? sg0 : sg2;
    b  = (lat == 0) ? b0  : b2;
    d  = (lat == 0) ? d0  : d2;
    p  = (lat == 0) ? p0  : p2;
  endtask

  task automatic set_start(input int lat, input logic v);
    if (lat == 0) start0 = v;
    else          start2 = v;
  endtask

  // Push the model's pattern stream, run one session, pop/compare each presented pattern.
  task automatic run_test(input int lat, input logic [3:0] sd, input int np,
                          input logic [3:0] es, input bit poke, input string tag);
    logic [3:0] s, m, ci, sg, last_p;
    logic       b, d, p;
    int         dr;
    s = (sd == 4'h0) ? 4'h1 : sd;
    m = 4'h0;
    last_p = 4'h0;
    pat_q.delete();
    for (int i = 0; i < np; i++) begin
      pat_q.push_back(s);
      m = gstep(m, s);
      s = gstep(s, 4'h0);
    end
    @(negedge clk);
    seed = sd; num_patterns = 16'(np); exp_sig = es;
    set_start(lat, 1'b1);
    @(negedge clk);
    set_start(lat, 1'b0);
    peek(lat, ci, sg, b, d, p);
    chk({tag, ".seed_busy"}, 32'(b), 1);
    chk({tag, ".seed_done"}, 32'(d), 0);
    for (int i = 0; i < np; i++) begin
      @(negedge clk);
      peek(lat, ci, sg, b, d, p);
      last_p = pat_q.pop_front();
      chk($sformatf("%s.pat%0d", tag, i), 32'(ci), 32'(last_p));
      if (poke && i == 1) begin
        seed = 4'h9; num_patterns = 16'd2;
        set_start(lat, 1'b1);
      end else begin
        set_start(lat, 1'b0);
      end
    end
    set_start(lat, 1'b0);
    dr = (np > 0) ? lat : 0;
    for (int i = 0; i < dr; i++) begin
      @(negedge clk);
      peek(lat, ci, sg, b, d, p);
      chk($sformatf("%s.drain%0d_busy", tag, i), 32'(b), 1);
      chk($sformatf("%s.drain%0d_done", tag, i), 32'(d), 0);
      chk($sformatf("%s.drain%0d_hold", tag, i), 32'(ci), 32'(last_p));
    end
    @(negedge clk);
    peek(lat, ci, sg, b, d, p);
    chk({tag, ".done"}, 32'(d), 1);
    chk({tag, ".busy"}, 32'(b), 0);
    chk({tag, ".sig"},  32'(sg), 32'(m));
    chk({tag, ".pass"}, 32'(p), 32'(m == es));
  endtask

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start2 = 1'b0; abort = 1'b0;
    seed = '0; num_patterns = '0; exp_sig = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst.cut_in0", 32'(ci0), 0);
    chk("rst.sig0",    32'(sg0), 0);
    chk("rst.busy0",   32'(b0), 0);
    chk("rst.done0",   32'(d0), 0);
    chk("rst.pass0",   32'(p0), 0);
    chk("rst.cut_in2", 32'(ci2), 0);
    chk("rst.sig2",    32'(sg2), 0);
    chk("rst.done2",   32'(d2), 0);

    run_test(0, 4'h1, 3,  4'h4, 1'b0, "lb3");
    chk("lb3.sig_const", 32'(sg0), 32'h4);
    run_test(0, 4'h1, 16, 4'h0, 1'b0, "lb16");
    chk("lb16.wrap", 32'(ci0), 32'h1);
    run_test(0, 4'h0, 3,  4'h4, 1'b0, "seed0");
    run_test(2, 4'h1, 3,  4'h4, 1'b0, "lat2");
    repeat (3) @(negedge clk);
    chk("lat2.sig_stable", 32'(sg2), 32'h4);
    chk("lat2.done_held",  32'(d2), 1);
    run_test(0, 4'h1, 0,  4'h0, 1'b0, "np0a");
    run_test(0, 4'h1, 0,  4'h5, 1'b0, "np0b");
    run_test(2, 4'h7, 0,  4'h0, 1'b0, "np0lat2");
    run_test(0, 4'h3, 6,  4'h0, 1'b1, "poke");
    run_test(2, 4'hA, 9,  4'h0, 1'b0, "lat2long");

    // abort out of DONE
    run_test(0, 4'h1, 3, 4'h4, 1'b0, "predone");
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_done.done", 32'(d0), 0);
    chk("abort_done.pass", 32'(p0), 0);
    chk("abort_done.sig",  32'(sg0), 32'h4);

    // abort in RUN cycle 2
    @(negedge clk); seed = 4'h1; num_patterns = 16'd10; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    @(negedge clk);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_run.busy", 32'(b0), 0);
    chk("abort_run.done", 32'(d0), 0);
    repeat (3) @(negedge clk);
    chk("abort_run.idle_busy", 32'(b0), 0);
    chk("abort_run.idle_done", 32'(d0), 0);

    // reset mid-RUN
    @(negedge clk); seed = 4'h5; num_patterns = 16'd10; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("rst_run.cut_in", 32'(ci0), 0);
    chk("rst_run.sig",    32'(sg0), 0);
    chk("rst_run.busy",   32'(b0), 0);
    chk("rst_run.done",   32'(d0), 0);
    chk("rst_run.pass",   32'(p0), 0);

    run_test(0, 4'h6, 5, 4'h0, 1'b0, "recover");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
